// File: rtl/matrix_pkg.sv
// Shared types, constants and width/index helpers for the sequential 2x2
// matrix multiply / determinant unit.
// Optional macro MATRIX_PIPE_MUL_EN selects a registered multiplier output
// (MAC_LAT = 1) instead of a combinational multiply-accumulate (MAC_LAT = 0).
package matrix_pkg;

    typedef enum logic [1:0] {IDLE, MUL, DET, DONE} state_e;

    typedef enum logic [1:0] {MAC_NOP, MAC_LOAD, MAC_ADD, MAC_SUB} mac_op_e;

    localparam int unsigned MUL_STEPS = 8;
    localparam int unsigned DET_STEPS = 2;

`ifdef MATRIX_PIPE_MUL_EN
    localparam int unsigned MAC_LAT = 1;
`else
    localparam int unsigned MAC_LAT = 0;
`endif

    // Signed width of a C element: exact sum of two WIDTH x WIDTH products.
    function automatic int unsigned c_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

    // Signed width of det(C): exact difference of two CW x CW products.
    function automatic int unsigned d_width(input int unsigned w);
        return 2 * c_width(w) + 1;
    endfunction

    // LSB of element idx (0 = x00 ... 3 = x11) in a vector packed x00-first.
    function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned w);
        return (3 - idx) * w;
    endfunction

endpackage

// File: rtl/matrix_seq_mac.sv
// Time-shared signed CW x CW multiplier with a DW-bit accumulator.
// Ports: clk, rst_n; clr (clear accumulator/pipe); op (NOP/LOAD/ADD/SUB);
//        a, b (signed operands); result_c (value the accumulator takes for the
//        op landing this cycle); res_valid_c (an ADD/SUB result is landing).
// With MATRIX_PIPE_MUL_EN defined the product and its op are registered, so
// every op lands one cycle after it is issued.
module matrix_seq_mac
    import matrix_pkg::*;
#(
    parameter int unsigned CW = 15,
    parameter int unsigned DW = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  mac_op_e              op,
    input  logic signed [CW-1:0] a,
    input  logic signed [CW-1:0] b,
    output logic signed [DW-1:0] result_c,
    output logic                 res_valid_c
);

    localparam int unsigned PW = 2 * CW;

    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] prod_s;
    logic signed [DW-1:0] prod_ext;
    logic signed [DW-1:0] acc_q;
    mac_op_e              op_s;

    assign prod_c = PW'(a) * PW'(b);

`ifdef MATRIX_PIPE_MUL_EN
    logic signed [PW-1:0] prod_q;
    mac_op_e              op_q;

    // Multiplier output register; clr flushes any op still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            op_q   <= MAC_NOP;
        end else if (clr) begin
            prod_q <= '0;
            op_q   <= MAC_NOP;
        end else begin
            prod_q <= prod_c;
            op_q   <= op;
        end
    end

    assign prod_s = prod_q;
    assign op_s   = op_q;
`else
    assign prod_s = prod_c;
    assign op_s   = op;
`endif

    assign prod_ext    = DW'(prod_s);
    assign res_valid_c = (op_s == MAC_ADD) || (op_s == MAC_SUB);

    // Accumulator next value for the op landing this cycle.
    always_comb begin
        result_c = acc_q;
        case (op_s)
            MAC_LOAD: result_c = prod_ext;
            MAC_ADD:  result_c = acc_q + prod_ext;
            MAC_SUB:  result_c = acc_q - prod_ext;
            default:  result_c = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (op_s != MAC_NOP) begin
            acc_q <= result_c;
        end
    end

endmodule

// File: rtl/matrix_2x2_seq_mult_det.sv
// Sequential 2x2 signed matrix multiply C = A*B with optional det(C), using a
// single time-shared multiplier (matrix_seq_mac).
// Ports: clk, rst_n; in_valid/in_ready, mode_det, matA, matB (operand side);
//        out_valid/out_ready, matC, determinant (result side).
// Macro MATRIX_PIPE_MUL_EN adds a multiplier pipeline stage (one drain cycle
// per phase, latencies 9/12 instead of 8/10).
module matrix_2x2_seq_mult_det
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          mode_det,
    input  logic [4*WIDTH-1:0]            matA,
    input  logic [4*WIDTH-1:0]            matB,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*c_width(WIDTH)-1:0]   matC,
    output logic [d_width(WIDTH)-1:0]     determinant
);

    localparam int unsigned CW       = c_width(WIDTH);
    localparam int unsigned DW       = d_width(WIDTH);
    localparam int unsigned STEP_W   = 4;
    localparam int unsigned MUL_LAST = MUL_STEPS - 1 + MAC_LAT;
    localparam int unsigned DET_LAST = DET_STEPS - 1 + MAC_LAT;

    state_e                   state_q, state_nxt;
    logic [STEP_W-1:0]        step_q, step_nxt;
    logic [4*WIDTH-1:0]       a_q, b_q;
    logic                     mode_q;
    logic signed [WIDTH-1:0]  a_e [4];
    logic signed [WIDTH-1:0]  b_e [4];
    logic signed [CW-1:0]     c_q [4];
    logic signed [CW-1:0]     c_nxt [4];
    logic signed [DW-1:0]     det_q, det_nxt;
    logic [1:0]               wr_q, wr_nxt;
    logic [4*CW-1:0]          c_pack_c;

    logic                     clr_c;
    mac_op_e                  op_c;
    logic signed [CW-1:0]     opa_c, opb_c;
    logic signed [DW-1:0]     result_c;
    logic                     res_valid_c;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign a_e[g] = $signed(a_q[elem_lsb(g, WIDTH) +: WIDTH]);
        assign b_e[g] = $signed(b_q[elem_lsb(g, WIDTH) +: WIDTH]);
    end

    assign c_pack_c = {c_nxt[0], c_nxt[1], c_nxt[2], c_nxt[3]};

    matrix_seq_mac #(.CW(CW), .DW(DW)) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr_c),
        .op          (op_c),
        .a           (opa_c),
        .b           (opb_c),
        .result_c    (result_c),
        .res_valid_c (res_valid_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_nxt;
            step_q  <= step_nxt;
        end
    end

    // Next state, step counter and MAC issue. Step k selects a{k2,k0}*b{k0,k1},
    // which walks the product order a00b00, a01b10, a00b01, a01b11, ...
    always_comb begin
        state_nxt = state_q;
        step_nxt  = step_q;
        op_c      = MAC_NOP;
        clr_c     = 1'b0;
        opa_c     = '0;
        opb_c     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = MUL;
                    step_nxt  = '0;
                    clr_c     = 1'b1;
                end
            end
            MUL: begin
                step_nxt = step_q + STEP_W'(1);
                if (step_q < STEP_W'(MUL_STEPS)) begin
                    op_c  = step_q[0] ? MAC_ADD : MAC_LOAD;
                    opa_c = CW'(a_e[{step_q[2], step_q[0]}]);
                    opb_c = CW'(b_e[{step_q[0], step_q[1]}]);
                end
                if (step_q == STEP_W'(MUL_LAST)) begin
                    step_nxt  = '0;
                    state_nxt = mode_q ? DET : DONE;
                end
            end
            DET: begin
                step_nxt = step_q + STEP_W'(1);
                if (step_q == STEP_W'(0)) begin
                    op_c  = MAC_LOAD;
                    opa_c = c_q[0];
                    opb_c = c_q[3];
                end else if (step_q == STEP_W'(1)) begin
                    op_c  = MAC_SUB;
                    opa_c = c_q[1];
                    opb_c = c_q[2];
                end
                if (step_q == STEP_W'(DET_LAST)) begin
                    step_nxt  = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result capture: C elements fill in landing order, det on the SUB result.
    always_comb begin
        c_nxt   = c_q;
        det_nxt = det_q;
        wr_nxt  = wr_q;
        if ((state_q == IDLE) && in_valid) begin
            c_nxt   = '{default: '0};
            det_nxt = '0;
            wr_nxt  = '0;
        end else if (res_valid_c) begin
            if (state_q == MUL) begin
                c_nxt[wr_q] = result_c[CW-1:0];
                wr_nxt      = wr_q + 2'd1;
            end else if (state_q == DET) begin
                det_nxt = result_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            c_q    <= '{default: '0};
            det_q  <= '0;
            wr_q   <= '0;
        end else begin
            if ((state_q == IDLE) && in_valid) begin
                a_q    <= matA;
                b_q    <= matB;
                mode_q <= mode_det;
            end
            c_q   <= c_nxt;
            det_q <= det_nxt;
            wr_q  <= wr_nxt;
        end
    end

    // Outputs change only on entry to DONE, so no partial result is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            matC        <= '0;
            determinant <= '0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if ((state_q != DONE) && (state_nxt == DONE)) begin
                matC        <= c_pack_c;
                determinant <= mode_q ? det_nxt : '0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_2x2_seq_mult_det.sv
// Directed self-checking bench for matrix_2x2_seq_mult_det (WIDTH = 7).
module tb_matrix_2x2_seq_mult_det;

    localparam int unsigned WIDTH = 7;
    localparam int unsigned CW    = 15;
    localparam int unsigned DW    = 31;

`ifdef MATRIX_PIPE_MUL_EN
    localparam int LAT_P = 9;
    localparam int LAT_D = 12;
`else
    localparam int LAT_P = 8;
    localparam int LAT_D = 10;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode_det;
    logic [4*WIDTH-1:0]   matA;
    logic [4*WIDTH-1:0]   matB;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*CW-1:0]      matC;
    logic [DW-1:0]        determinant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matrix_2x2_seq_mult_det #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode_det    (mode_det),
        .matA        (matA),
        .matB        (matB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .matC        (matC),
        .determinant (determinant)
    );

    function automatic logic [4*WIDTH-1:0] pk7(input int e0, input int e1, input int e2, input int e3);
        return {7'(e0), 7'(e1), 7'(e2), 7'(e3)};
    endfunction

    function automatic logic [4*CW-1:0] pk15(input int e0, input int e1, input int e2, input int e3);
        return {15'(e0), 15'(e1), 15'(e2), 15'(e3)};
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input longint d);
        chk({tag, "_matC"}, longint'(matC), longint'(pk15(e0, e1, e2, e3)));
        chk({tag, "_c11"}, longint'($signed(matC[CW-1:0])), longint'(e3));
        chk({tag, "_det"}, longint'($signed(determinant)), d);
    endtask

    // Present one job at a negedge, accept on the next posedge, then scramble inputs.
    task automatic submit(input string tag, input logic [4*WIDTH-1:0] a,
                          input logic [4*WIDTH-1:0] b, input logic m);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_in_ready"}, longint'(in_ready), 1);
        matA     = a;
        matB     = b;
        mode_det = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        matA     = 28'($urandom);
        matB     = 28'($urandom);
        mode_det = ~m;
    endtask

    // Edges from accept until out_valid is seen high (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, longint'(out_valid), 0);
        chk({tag, "_ready_back"}, longint'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int saw_valid;
        logic [4*CW-1:0] held_c;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode_det  = 1'b0;
        matA      = '0;
        matB      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_matC", longint'(matC), 0);
        chk("rst_det", longint'(determinant), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: product + determinant
        submit("t1", pk7(1, 2, 3, 4), pk7(5, 6, 7, 8), 1'b1);
        wait_out(lat);
        chk("t1_latency", longint'(lat), longint'(LAT_D));
        check_res("t1", 19, 22, 43, 50, 4);
        release_out("t1");

        // 2: product only
        submit("t2", pk7(1, 2, 3, 4), pk7(5, 6, 7, 8), 1'b0);
        wait_out(lat);
        chk("t2_latency", longint'(lat), longint'(LAT_P));
        check_res("t2", 19, 22, 43, 50, 0);
        release_out("t2");

        // 3: most negative operands, out_ready held high throughout
        out_ready = 1'b1;
        submit("t3", pk7(-64, -64, -64, -64), pk7(-64, -64, -64, -64), 1'b1);
        wait_out(lat);
        chk("t3_latency", longint'(lat), longint'(LAT_D));
        check_res("t3", 8192, 8192, 8192, 8192, 0);
        @(posedge clk);
        #1;
        chk("t3_one_cycle_valid", longint'(out_valid), 0);
        out_ready = 1'b0;

        // 4: full-width positive determinant
        submit("t4", pk7(-64, 0, 0, -64), pk7(-64, 0, 0, -64), 1'b1);
        wait_out(lat);
        chk("t4_latency", longint'(lat), longint'(LAT_D));
        check_res("t4", 4096, 0, 0, 4096, 64'sd16777216);
        release_out("t4");

        // 5: backpressure in DONE while inputs toggle, then back-to-back accept
        submit("t5", pk7(1, 2, 3, 4), pk7(5, 6, 7, 8), 1'b1);
        wait_out(lat);
        chk("t5_latency", longint'(lat), longint'(LAT_D));
        held_c = pk15(19, 22, 43, 50);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            matA     = 28'($urandom);
            in_valid = ~in_valid;
            @(posedge clk);
            #1;
            chk("t5_hold_valid", longint'(out_valid), 1);
            chk("t5_hold_ready", longint'(in_ready), 0);
            chk("t5_hold_matC", longint'(matC), longint'(held_c));
            chk("t5_hold_det", longint'($signed(determinant)), 4);
        end
        in_valid = 1'b0;
        release_out("t5");
        submit("t5b", pk7(1, 2, 3, 4), pk7(5, 6, 7, 8), 1'b0);
        wait_out(lat);
        chk("t5b_latency", longint'(lat), longint'(LAT_P));
        check_res("t5b", 19, 22, 43, 50, 0);
        release_out("t5b");

        // 6: reset during MUL step 4 aborts the job
        submit("t6", pk7(-3, 5, 7, -2), pk7(4, -6, 1, 3), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", longint'(out_valid), 0);
        chk("t6_rst_in_ready", longint'(in_ready), 1);
        chk("t6_rst_matC", longint'(matC), 0);
        chk("t6_rst_det", longint'(determinant), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1;
        end
        chk("t6_no_aborted_result", longint'(saw_valid), 0);
        submit("t6b", pk7(1, 2, 3, 4), pk7(5, 6, 7, 8), 1'b1);
        wait_out(lat);
        chk("t6b_latency", longint'(lat), longint'(LAT_D));
        check_res("t6b", 19, 22, 43, 50, 4);
        release_out("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_2x2_seq_mult_det.md
Name: matrix_2x2_seq_mult_det

Overview:
Sequential successor to the combinational 2x2 matrix multiplier/determinant unit. It computes C = A*B for signed 2x2 matrices and, optionally per transaction, det(C), using one time-shared signed multiplier. Result widths are full precision, so no element or determinant can overflow. It sits between the matrix operand source and the result consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 7, signed bit width of each A/B element.
CW, 2*WIDTH+1, derived (localparam): signed width of each C element.
DW, 2*CW+1, derived (localparam): signed width of the determinant.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and mode are valid
in_ready  out  1  block accepts operands
mode_det  in  1  1 = also compute det(C); 0 = product only
matA  in  4*WIDTH  {a00,a01,a10,a11}, a00 in the MSBs, each element signed
matB  in  4*WIDTH  {b00,b01,b10,b11}, same packing as matA
out_valid  out  1  result is valid
out_ready  in  1  consumer accepts the result
matC  out  4*CW  {c00,c01,c10,c11}, each element signed
determinant  out  DW  signed det(C); 0 when mode_det was 0

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, matC=0, determinant=0, step counter=0, accumulator=0.
- States: IDLE -> MUL -> (DET if latched mode_det) -> DONE -> IDLE.
- IDLE: in_ready=1. A clock edge with in_valid=1 latches matA, matB and mode_det, clears the accumulator, goes to MUL with step=0.
- in_ready=0 in MUL, DET and DONE. There is no overlap: the next accept happens at the earliest on the cycle after DONE exits.
- MUL: 8 steps, k=0..7, one product per cycle.
  - Product order: a00*b00, a01*b10, a00*b01, a01*b11, a10*b00, a11*b10, a10*b01, a11*b11.
  - Even step: acc = product. Odd step: C[k/2] = acc + product.
- Operands are sign-extended to CW before the multiply. Products are exact; sums are exact in CW bits.
- DET: 2 steps. Step 0: acc = c00*c11. Step 1: determinant = acc - c01*c10, computed in DW bits.
- Product-only transaction (mode_det=0): DET is skipped and determinant is written 0.
- Latency from the accept edge to out_valid high:
  - 8 cycles for product only.
  - 10 cycles with the determinant.
- DONE: out_valid=1. matC and determinant are held stable while out_ready=0. An edge with out_ready=1 drops out_valid and returns to IDLE. Outputs keep their last values after DONE.
- in_valid while busy is ignored; the source must hold it until in_ready.
- out_ready while not in DONE has no effect.
- A reset asserted mid-transaction aborts it immediately; no partial result is ever presented.
- Latched operands are the only source during computation; input changes after accept have no effect.

Optional Feature:
MATRIX_PIPE_MUL_EN
- Defined: adds a register stage at the multiplier output for timing closure. Products are issued one per cycle and land one cycle later, and each phase adds one drain cycle. Latency is 9 cycles (product only) and 12 cycles (with determinant). Results are identical.
- Undefined: combinational multiply-accumulate, with latencies 8 and 10.

Decomposition:
- Package matrix_pkg:
  - state enum {IDLE, MUL, DET, DONE}.
  - constants MUL_STEPS=8, DET_STEPS=2.
  - functions c_width(w)=2*w+1 and d_width(w)=2*c_width(w)+1.
  - pack/unpack index helpers for 4-element matrix vectors.
- Sub-module matrix_seq_mac: signed CW x CW multiplier with accumulator, load/accumulate/subtract controls, and an optional pipeline register under MATRIX_PIPE_MUL_EN. The controller FSM lives in the top.

Test Plan:
1. WIDTH=7, A=[1 2;3 4], B=[5 6;7 8], mode_det=1 -> C=[19 22;43 50], det=4, out_valid exactly 10 cycles after accept (12 with MATRIX_PIPE_MUL_EN).
2. Same operands, mode_det=0 -> C=[19 22;43 50], det=0, latency 8 (9 with the macro).
3. A=B=all -64, mode_det=1 -> every C element=8192 (no overflow in 15 bits), det=0.
4. A=[-64 0;0 -64], B=[-64 0;0 -64] -> C=[4096 0;0 4096], det=16777216 (full-width positive, DW=31).
5. Hold out_ready=0 for 5 cycles in DONE while toggling matA/in_valid -> outputs stable, in_ready=0, no second accept. out_ready=1 -> IDLE, then back-to-back accept on the next cycle.
6. Assert rst_n=0 at MUL step 4, release, submit A=[1 2;3 4], B=[5 6;7 8] -> out_valid never asserted for the aborted job; all outputs 0 during reset; new result correct.
